ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Hazard and forwarding controller for the EX stage.
- Keeps an in-flight write scoreboard for EX, MEM and WB, and generates the registered rs1_sel/rs2_sel forwarding selects used by the EX-stage operand muxes.
- Detects load-use hazards and inserts a one-cycle stall plus bubble.
- Flushes wrong-path IF/ID and ID/EX contents on a branch/jump redirect reported by EX. Includes saturating stall and flush counters for performance monitoring.

Parameters:
- CNT_W, 16: width of the stall_cnt and flush_cnt performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1_addr  in  5  ID source register 1
- id_rs2_addr  in  5  ID source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_wa  in  5  ID destination register
- id_regWrite  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a LOAD
- br_res  in  2  EX branch result; nonzero means a redirect is taken this cycle
- stall_fe  out  1  hold PC and IF/ID
- bubble_ex  out  1  load ID/EX with a NOP (regWrite=0, memWrite=0)
- flush_if_id  out  1  invalidate IF/ID
- flush_id_ex  out  1  invalidate ID/EX
- rs1_sel  out  2  registered; 0 = RF value, 1 = wb_wd, 2 = mem_wd
- rs2_sel  out  2  same encoding as rs1_sel
- stall_cnt  out  CNT_W  load-use stall cycles, saturating
- flush_cnt  out  CNT_W  redirects taken, saturating

Behaviour:
- Reset: async on rst_n low. All three scoreboard entries invalid, FSM in RUN, every output 0 (including both sels and both counters).
- Scoreboard:
  - Entries EX, MEM, WB; each holds {valid, wa, regWrite, is_load}.
  - Shifts every cycle: WB<=MEM, MEM<=EX.
  - EX<=ID fields when ID advances; EX<=invalid when bubble_ex or flush_id_ex is asserted.
  - EX, MEM and WB never stall.
- Match rule: entry matches source r when valid & regWrite & wa==r & r!=0. x0 is never forwarded and never stalls.
- Forward selects:
  - Computed in ID for each used source, registered on the edge the instruction enters EX. Valid for exactly that instruction's EX cycle.
  - Current EX entry match gives 2 (mem_wd next cycle).
  - Otherwise current MEM entry match gives 1 (wb_wd next cycle).
  - Otherwise 0. The RF is write-first, so the WB entry needs no forward.
  - EX has priority over MEM.
  - Unused source gives 0. Bubble or flush registers 0.
- Load-use:
  - Triggered when id_valid, the EX entry is_load, and the EX entry matches a used source.
  - stall_fe=1 and bubble_ex=1 combinationally that cycle; FSM goes RUN->STALL; stall_cnt increments.
  - In STALL no new load-use is possible, because the EX slot is a bubble. The held instruction re-evaluates and gets sel=1 from the load now in MEM. STALL->RUN unconditionally.
- Redirect:
  - br_res!=0 while the EX entry is valid: flush_if_id=1 and flush_id_ex=1 combinationally; FSM ->FLUSH; flush_cnt increments.
  - FLUSH asserts flush_if_id one more cycle to cover the registered IMEM read latency. FLUSH->RUN unless a new redirect arrives.
  - br_res is ignored when the EX entry is invalid.
- Priority: redirect beats load-use in the same cycle. stall_fe=0 and bubble_ex=0, the stall is dropped, and stall_cnt does not increment.
- Counters saturate at all-ones with no wrap.
- Reset mid-stall or mid-flush returns immediately to the reset state.

Test Plan:
- RAW on ALU result: add x5 in EX, ID reads rs1=x5 -> next cycle rs1_sel=2, rs2_sel=0, no stall.
- Two-ahead RAW: x5 writer in MEM, EX entry unrelated, ID rs2=x5 -> rs2_sel=1. With both EX and MEM writing x5 -> rs2_sel=2.
- Load-use: lw x7 in EX, ID add uses rs1=x7 -> stall_fe=1 and bubble_ex=1 for exactly 1 cycle, then rs1_sel=1, stall_cnt=1. With rs1=x0 instead -> no stall.
- Redirect: br_res=2'b01 with EX valid -> flush_if_id=1 for 2 cycles, flush_id_ex=1 for 1 cycle, flush_cnt=1. With br_res=01 and EX entry invalid -> no flush.
- Simultaneous redirect and load-use -> flush asserted, stall_fe=0, stall_cnt unchanged. Force stall_cnt to 16'hFFFF and trigger a stall -> stays 16'hFFFF.
- Assert rst_n low during FLUSH -> all outputs 0 asynchronously, sels 0, counters 0.

Source files
------------

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: in-flight write scoreboard, registered operand
// forwarding selects, load-use stall/bubble, redirect flush and perf counters.
module ex_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_wa,
    input  logic             id_regWrite,
    input  logic             id_is_load,
    input  logic [1:0]       br_res,
    output logic             stall_fe,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [1:0]       rs1_sel,
    output logic [1:0]       rs2_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] wa;
        logic       reg_write;
        logic       is_load;
    } sb_entry_t;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_WB  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    state_t    state;
    sb_entry_t ex_q, mem_q, wb_q;

    logic load_use;
    logic redirect;
    logic stall;

    // x0 is hardwired, so a write to it never produces a dependency.
    function automatic logic hits(input sb_entry_t e, input logic [4:0] r);
        return e.valid && e.reg_write && (e.wa == r) && (r != 5'd0);
    endfunction

    // EX entry result appears on mem_wd next cycle, MEM entry result on wb_wd.
    function automatic logic [1:0] fwd_sel(input sb_entry_t ex_e, input sb_entry_t mem_e,
                                           input logic uses, input logic [4:0] r);
        if (!uses)             return SEL_RF;
        else if (hits(ex_e, r))  return SEL_MEM;
        else if (hits(mem_e, r)) return SEL_WB;
        else                   return SEL_RF;
    endfunction

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        load_use = 1'b0;
        redirect = 1'b0;
        stall    = 1'b0;
        if (id_valid && ex_q.is_load)
            load_use = (id_uses_rs1 && hits(ex_q, id_rs1_addr)) ||
                       (id_uses_rs2 && hits(ex_q, id_rs2_addr));
        redirect = (br_res != 2'b00) && ex_q.valid;
        stall    = load_use && !redirect;
    end

    assign stall_fe    = stall;
    assign bubble_ex   = stall;
    assign flush_id_ex = redirect;
    // The extra FLUSH cycle covers the wrong-path fetch already in flight in IMEM.
    assign flush_if_id = redirect || (state == FLUSH);

    // WB entry is tracked for completeness; the write-first RF needs no forward from it.
    logic unused_wb;
    assign unused_wb = ^wb_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            rs1_sel   <= SEL_RF;
            rs2_sel   <= SEL_RF;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;

            if (stall || redirect) begin
                ex_q    <= '0;
                rs1_sel <= SEL_RF;
                rs2_sel <= SEL_RF;
            end else begin
                ex_q.valid     <= id_valid;
                ex_q.wa        <= id_wa;
                ex_q.reg_write <= id_regWrite;
                ex_q.is_load   <= id_is_load;
                rs1_sel <= id_valid ? fwd_sel(ex_q, mem_q, id_uses_rs1, id_rs1_addr) : SEL_RF;
                rs2_sel <= id_valid ? fwd_sel(ex_q, mem_q, id_uses_rs2, id_rs2_addr) : SEL_RF;
            end

            if (redirect)   state <= FLUSH;
            else if (stall) state <= STALL;
            else            state <= RUN;

            if (stall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Self-checking bench for ex_hazard_ctrl: directed pipeline sequences with a
// queue of expected forwarding selects, plus a narrow-counter instance for saturation.
module tb_ex_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_wa;
    logic       id_uses_rs1, id_uses_rs2, id_regWrite, id_is_load;
    logic [1:0] br_res;

    logic        stall_fe, bubble_ex, flush_if_id, flush_id_ex;
    logic [1:0]  rs1_sel, rs2_sel;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall_fe, s_bubble_ex, s_flush_if_id, s_flush_id_ex;
    logic [1:0]  s_rs1_sel, s_rs2_sel;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] sel_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    ex_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_wa(id_wa), .id_regWrite(id_regWrite), .id_is_load(id_is_load),
        .br_res(br_res), .stall_fe(stall_fe), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Same stimulus, 2-bit counters so saturation is reachable in a few stalls.
    ex_hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_wa(id_wa), .id_regWrite(id_regWrite), .id_is_load(id_is_load),
        .br_res(br_res), .stall_fe(s_stall_fe), .bubble_ex(s_bubble_ex),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .rs1_sel(s_rs1_sel), .rs2_sel(s_rs2_sel),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_sel();
        logic [3:0] s;
        string      t;
        if (sel_q.size() > 0) begin
            s = sel_q.pop_front();
            t = tag_q.pop_front();
            check({t, " rs1_sel"}, rs1_sel, s[3:2]);
            check({t, " rs2_sel"}, rs2_sel, s[1:0]);
        end
    endtask

    // One pipeline cycle: check the selects registered by the previous edge,
    // drive ID/EX inputs, check the combinational controls, queue the selects
    // that the coming edge must register.
    task automatic cyc(input string tag, input logic v,
                       input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] wa, input logic rw, input logic ld,
                       input logic [1:0] br, input logic [1:0] e1, input logic [1:0] e2,
                       input logic e_stall, input logic e_fi, input logic e_fx);
        @(negedge clk);
        pop_sel();
        id_valid    = v;
        id_rs1_addr = r1;
        id_uses_rs1 = u1;
        id_rs2_addr = r2;
        id_uses_rs2 = u2;
        id_wa       = wa;
        id_regWrite = rw;
        id_is_load  = ld;
        br_res      = br;
        #1;
        check({tag, " stall_fe"},    stall_fe,    e_stall);
        check({tag, " bubble_ex"},   bubble_ex,   e_stall);
        check({tag, " flush_if_id"}, flush_if_id, e_fi);
        check({tag, " flush_id_ex"}, flush_id_ex, e_fx);
        sel_q.push_back({e1, e2});
        tag_q.push_back(tag);
    endtask

    task automatic idle(input string tag, input logic [1:0] br, input logic e_fi, input logic e_fx);
        cyc(tag, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, br, 2'd0, 2'd0, 1'b0, e_fi, e_fx);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " stall_fe"},    stall_fe,    0);
        check({tag, " bubble_ex"},   bubble_ex,   0);
        check({tag, " flush_if_id"}, flush_if_id, 0);
        check({tag, " flush_id_ex"}, flush_id_ex, 0);
        check({tag, " rs1_sel"},     rs1_sel,     0);
        check({tag, " rs2_sel"},     rs2_sel,     0);
        check({tag, " stall_cnt"},   stall_cnt,   0);
        check({tag, " flush_cnt"},   flush_cnt,   0);
        check({tag, " sat stall_cnt"}, s_stall_cnt, 0);
        check({tag, " sat flush_cnt"}, s_flush_cnt, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs1 = 1'b0;
        id_uses_rs2 = 1'b0; id_wa = '0; id_regWrite = 1'b0; id_is_load = 1'b0; br_res = '0;
        #1;
        check_reset_state("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // RAW forwarding from EX and from MEM, EX priority, x0 and unused sources
        cyc("alu_wr",   1, 0, 0, 0,  0, 5,  1, 0, 0, 0, 0, 0, 0, 0);
        cyc("raw_ex",   1, 5, 1, 6,  1, 8,  1, 0, 0, 2, 0, 0, 0, 0);
        cyc("raw_mem",  1, 3, 1, 5,  1, 9,  1, 0, 0, 0, 1, 0, 0, 0);
        cyc("wr5_a",    1, 0, 0, 0,  0, 5,  1, 0, 0, 0, 0, 0, 0, 0);
        cyc("wr5_b",    1, 0, 0, 0,  0, 5,  1, 0, 0, 0, 0, 0, 0, 0);
        cyc("raw_prio", 1, 0, 0, 5,  1, 10, 1, 0, 0, 0, 2, 0, 0, 0);
        cyc("wr_x0",    1, 0, 0, 0,  0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
        cyc("rd_x0",    1, 0, 1, 10, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use: one-cycle stall, then forward from MEM
        cyc("lw7",      1, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0, 0, 0);
        cyc("lu_stall", 1, 7, 1, 2, 1, 12, 1, 0, 0, 0, 0, 1, 0, 0);
        cyc("lu_held",  1, 7, 1, 2, 1, 12, 1, 0, 0, 1, 0, 0, 0, 0);
        check("lu stall_cnt", stall_cnt, 1);
        cyc("lw_x0",    1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0);
        cyc("lu_x0",    1, 0, 1, 3, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
        check("lu_x0 stall_cnt", stall_cnt, 1);

        // Redirect with valid EX, then br_res with EX empty
        cyc("redir", 1, 0, 0, 0, 0, 14, 1, 0, 2'b01, 0, 0, 0, 1, 1);
        idle("flush_hold", 2'b00, 1, 0);
        check("redir flush_cnt", flush_cnt, 1);
        idle("post_flush", 2'b00, 0, 0);
        idle("br_ex_inv",  2'b01, 0, 0);
        cyc("lw7_b", 1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 0);
        check("br_ex_inv flush_cnt", flush_cnt, 1);

        // Redirect and load-use together: flush wins, no stall counted
        cyc("redir_lu", 1, 7, 1, 0, 0, 12, 1, 0, 2'b10, 0, 0, 0, 1, 1);
        idle("flush_hold2", 2'b00, 1, 0);
        check("redir_lu stall_cnt", stall_cnt, 1);
        check("redir_lu flush_cnt", flush_cnt, 2);
        check("redir_lu sat flush_cnt", s_flush_cnt, 2);
        idle("idle", 2'b00, 0, 0);

        // Repeated stalls: wide counter keeps counting, narrow one pins at all-ones
        for (int k = 1; k <= 4; k++) begin
            cyc("sat_lw",    1, 0, 0, 0, 0, 7,  1, 1, 0, 0, 0, 0, 0, 0);
            cyc("sat_stall", 1, 7, 1, 0, 0, 12, 1, 0, 0, 0, 0, 1, 0, 0);
            cyc("sat_held",  1, 7, 1, 0, 0, 12, 1, 0, 0, 1, 0, 0, 0, 0);
            check("sat stall_cnt wide", stall_cnt, 32'(1 + k));
            check("sat stall_cnt narrow", s_stall_cnt, (1 + k > 3) ? 32'd3 : 32'(1 + k));
        end

        // Reset asserted during the second FLUSH cycle
        cyc("pre_rst", 1, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 0, 0, 0);
        idle("rst_redir", 2'b01, 1, 1);
        @(negedge clk);
        pop_sel();
        check("flush_2nd flush_if_id", flush_if_id, 1);
        check("flush_2nd flush_cnt", flush_cnt, 3);
        rst_n = 1'b0;
        br_res = 2'b00;
        #1;
        check_reset_state("mid_flush_rst");
        sel_q.delete();
        tag_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        cyc("rec_wr",  1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("rec_raw", 1, 6, 1, 6, 1, 8, 1, 0, 0, 2, 2, 0, 0, 0);
        idle("rec_idle", 2'b00, 0, 0);
        @(negedge clk);
        pop_sel();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
